// File: rtl/tt_capture_pkg.sv
// -----------------------------------------------------------------------------
// tt_capture_pkg
// Shared definitions for the tt_capture truth-table sweeper:
//   state_e    - sweep FSM states
//   SETTLE_CW  - width of the settle counter (SETTLE range 0..15)
//   TT_W()     - packed truth-table width for a given input/output count
// -----------------------------------------------------------------------------
package tt_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  localparam int SETTLE_CW = 4;

  // One bit per (output, input vector) pair.
  function automatic int TT_W(input int n_in, input int n_out);
    return n_out * (1 << n_in);
  endfunction

endpackage

// File: rtl/tt_capture_idx.sv
// -----------------------------------------------------------------------------
// tt_capture_idx
// Input-vector index counter plus settle-cycle counter for tt_capture.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_clr            accepted start: both counters back to zero
//   i_cnt_en         DRIVE cycle: advance the settle counter
//   i_adv            SAMPLE of a non-terminal vector: step to the next index
//   o_idx            current index (N_IN+1 bits, never wraps)
//   o_x_nxt          low N_IN bits of the index after this edge
//   o_settle_done    settle counter is on the last DRIVE cycle
//   o_last           current index is the final input vector
// -----------------------------------------------------------------------------
module tt_capture_idx
  import tt_capture_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_cnt_en,
  input  logic            i_adv,
  output logic [N_IN:0]   o_idx,
  output logic [N_IN-1:0] o_x_nxt,
  output logic            o_settle_done,
  output logic            o_last
);

  localparam int IW = N_IN + 1;
  // SETTLE=0 never enters DRIVE, so the value used there is irrelevant.
  localparam logic [SETTLE_CW-1:0] SETTLE_LAST =
    (SETTLE > 0) ? SETTLE_CW'(SETTLE - 1) : {SETTLE_CW{1'b0}};
  localparam logic [IW-1:0] IDX_LAST = IW'((1 << N_IN) - 1);

  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [SETTLE_CW-1:0] r_cnt;
  logic [SETTLE_CW-1:0] w_cnt_nxt;
  logic                 w_settle_done;

  assign w_settle_done = (r_cnt == SETTLE_LAST);

  // Next index / settle count.
  always_comb begin
    w_idx_nxt = r_idx;
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_idx_nxt = {IW{1'b0}};
      w_cnt_nxt = {SETTLE_CW{1'b0}};
    end else if (i_adv) begin
      w_idx_nxt = r_idx + IW'(1);
      w_cnt_nxt = {SETTLE_CW{1'b0}};
    end else if (i_cnt_en) begin
      if (w_settle_done) begin
        w_cnt_nxt = {SETTLE_CW{1'b0}};
      end else begin
        w_cnt_nxt = r_cnt + SETTLE_CW'(1);
      end
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx <= {IW{1'b0}};
      r_cnt <= {SETTLE_CW{1'b0}};
    end else begin
      r_idx <= w_idx_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_idx         = r_idx;
  assign o_x_nxt       = w_idx_nxt[N_IN-1:0];
  assign o_settle_done = w_settle_done;
  assign o_last        = (r_idx == IDX_LAST);

endmodule

// File: rtl/tt_capture.sv
// -----------------------------------------------------------------------------
// tt_capture
// Exhaustive stimulus driver / response collector for a combinational circuit.
// Walks every input vector on o_x, waits SETTLE cycles, samples i_f and builds
// the packed truth table o_tt (bit o*2^N_IN + i = f[o] at x == i), then offers
// it on a valid/ready handshake.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_start          sweep request, honoured only in IDLE
//   o_x   / i_f      circuit stimulus / response
//   o_busy           sweep in progress
//   o_tt_valid       table available, held until i_tt_ready
//   o_tt             packed table, held until the next accepted start
// Optional macro TT_CAPTURE_CHECK_EN adds:
//   i_tt_exp         expected table
//   o_mismatch       per-output slice mismatch, valid while o_tt_valid
// -----------------------------------------------------------------------------
module tt_capture
  import tt_capture_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic [N_IN-1:0]               o_x,
  input  logic [N_OUT-1:0]              i_f,
  output logic                          o_busy,
  output logic                          o_tt_valid,
  input  logic                          i_tt_ready,
  output logic [TT_W(N_IN,N_OUT)-1:0]   o_tt
`ifdef TT_CAPTURE_CHECK_EN
  ,
  input  logic [TT_W(N_IN,N_OUT)-1:0]   i_tt_exp,
  output logic [N_OUT-1:0]              o_mismatch
`endif
);

  localparam int DEPTH = 1 << N_IN;
  localparam int TTW   = TT_W(N_IN, N_OUT);
  localparam int IW    = N_IN + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_clr;
  logic              w_cnt_en;
  logic              w_adv;
  logic              w_sample;
  logic [IW-1:0]     w_idx;
  logic [N_IN-1:0]   w_x_nxt;
  logic              w_settle_done;
  logic              w_last;
  logic [TTW-1:0]    r_tt;
  logic [TTW-1:0]    w_tt_nxt;
  logic [N_IN-1:0]   r_x;
  logic              r_busy;
  logic              r_valid;

  tt_capture_idx #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_idx (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (w_clr),
    .i_cnt_en      (w_cnt_en),
    .i_adv         (w_adv),
    .o_idx         (w_idx),
    .o_x_nxt       (w_x_nxt),
    .o_settle_done (w_settle_done),
    .o_last        (w_last)
  );

  // Sweep FSM next-state and counter controls.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_cnt_en    = 1'b0;
    w_adv       = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        w_cnt_en = 1'b1;
        if (w_settle_done) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_SAMPLE: begin
        w_sample = 1'b1;
        // Terminal check happens before increment so idx never wraps.
        if (w_last) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_adv       = 1'b1;
          w_state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;
        end
      end
      ST_OUT: begin
        // i_start is deliberately ignored here, even alongside i_tt_ready.
        if (i_tt_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next truth table: clear on start, write column idx of every output on sample.
  always_comb begin
    w_tt_nxt = r_tt;
    if (w_clr) begin
      w_tt_nxt = {TTW{1'b0}};
    end else if (w_sample) begin
      for (int o = 0; o < N_OUT; o++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_idx == IW'(i)) begin
            w_tt_nxt[o*DEPTH + i] = i_f[o];
          end else begin
            w_tt_nxt[o*DEPTH + i] = r_tt[o*DEPTH + i];
          end
        end
      end
    end else begin
      w_tt_nxt = r_tt;
    end
  end

  // State, table and registered outputs (decoded from the next state).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_tt    <= {TTW{1'b0}};
      r_x     <= {N_IN{1'b0}};
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tt    <= w_tt_nxt;
      r_busy  <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
      r_valid <= (w_state_nxt == ST_OUT);
      if ((w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE)) begin
        r_x <= w_x_nxt;
      end else begin
        r_x <= {N_IN{1'b0}};
      end
    end
  end

  assign o_x        = r_x;
  assign o_busy     = r_busy;
  assign o_tt_valid = r_valid;
  assign o_tt       = r_tt;

`ifdef TT_CAPTURE_CHECK_EN
  logic [N_OUT-1:0] r_mismatch;

  // Per-output compare captured on entry to OUT (uses the table being written
  // at that same edge), held through OUT, zero elsewhere.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mismatch <= {N_OUT{1'b0}};
    end else if ((w_state_nxt == ST_OUT) && (r_state != ST_OUT)) begin
      for (int o = 0; o < N_OUT; o++) begin
        r_mismatch[o] <= (w_tt_nxt[o*DEPTH +: DEPTH] != i_tt_exp[o*DEPTH +: DEPTH]);
      end
    end else if (w_state_nxt == ST_OUT) begin
      r_mismatch <= r_mismatch;
    end else begin
      r_mismatch <= {N_OUT{1'b0}};
    end
  end

  assign o_mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_tt_capture.sv
// -----------------------------------------------------------------------------
// tb_tt_capture
// Bench for tt_capture. dut0: N_IN=3, N_OUT=2, SETTLE=1 around the circuit
// f0 = x1|x2, f1 = x0|x1. dut1: SETTLE=0 around the constant circuit f=2'b01.
// Optional macro TT_CAPTURE_CHECK_EN connects the compare ports.
// -----------------------------------------------------------------------------
module tb_tt_capture;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, ready0, start1, ready1;
  logic [2:0]  x0, x1;
  logic [1:0]  f0, f1;
  logic        busy0, valid0, busy1, valid1;
  logic [15:0] tt0, tt1;

  // Circuits under test.
  assign f0 = {x0[0] | x0[1], x0[1] | x0[2]};
  assign f1 = 2'b01;

`ifdef TT_CAPTURE_CHECK_EN
  logic [15:0] exp0;
  logic [1:0]  mm0, mm1;
`endif

  tt_capture #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut0 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start0),
    .o_x        (x0),
    .i_f        (f0),
    .o_busy     (busy0),
    .o_tt_valid (valid0),
    .i_tt_ready (ready0),
    .o_tt       (tt0)
`ifdef TT_CAPTURE_CHECK_EN
    ,
    .i_tt_exp   (exp0),
    .o_mismatch (mm0)
`endif
  );

  tt_capture #(.N_IN(3), .N_OUT(2), .SETTLE(0)) dut1 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start1),
    .o_x        (x1),
    .i_f        (f1),
    .o_busy     (busy1),
    .o_tt_valid (valid1),
    .i_tt_ready (ready1),
    .o_tt       (tt1)
`ifdef TT_CAPTURE_CHECK_EN
    ,
    .i_tt_exp   (16'h00FF),
    .o_mismatch (mm1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [2:0] x;
    logic       busy;
    logic       valid;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [15:0] act);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0h, expected entry missing from scoreboard", name, act);
    end else begin
      e = sb_q.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference table: f0 = x1|x2, f1 = x0|x1, or the constant circuit 2'b01.
  function automatic logic [15:0] model_tt(input bit konst);
    logic [15:0] t;
    logic [2:0]  v;
    logic [1:0]  fv;
    t = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      fv = konst ? 2'b01 : {v[0] | v[1], v[1] | v[2]};
      t[i]     = fv[0];
      t[8 + i] = fv[1];
    end
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cycles;

    // Expected per-cycle outputs after the accepting edge (SETTLE=1):
    // two cycles per vector, then OUT.
    for (int j = 0; j < 17; j++) begin
      vecs[j].x     = (j < 16) ? 3'(j / 2) : 3'd0;
      vecs[j].busy  = (j < 16);
      vecs[j].valid = (j == 16);
    end

    rst    = 1'b1;
    start0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; ready1 = 1'b0;
`ifdef TT_CAPTURE_CHECK_EN
    exp0   = 16'hEEFD;
`endif
    #12;
    check("reset_x",     32'(x0),     32'd0);
    check("reset_busy",  32'(busy0),  32'd0);
    check("reset_valid", 32'(valid0), 32'd0);
    check("reset_tt",    32'(tt0),    32'd0);
    check("reset_tt1",   32'(tt1),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Sweep 1 with a stray start at DRIVE idx=3.
    start0 = 1'b1;
    sb_q.push_back(model_tt(1'b0));
    tick();
    start0 = 1'b0;
    for (int j = 0; j < 17; j++) begin
      if (j > 0) tick();
      check($sformatf("sweep_x[%0d]", j),     32'(x0),     32'(vecs[j].x));
      check($sformatf("sweep_busy[%0d]", j),  32'(busy0),  32'(vecs[j].busy));
      check($sformatf("sweep_valid[%0d]", j), 32'(valid0), 32'(vecs[j].valid));
      if (j == 16) begin
        pop_check("sweep_tt_sb", tt0);
        check("sweep_tt_const", 32'(tt0), 32'h0000EEFC);
`ifdef TT_CAPTURE_CHECK_EN
        check("mismatch_eefd", 32'(mm0), 32'd1);
`endif
      end
`ifdef TT_CAPTURE_CHECK_EN
      if (j == 8) check("mismatch_busy", 32'(mm0), 32'd0);
`endif
      start0 = (j == 6);
    end
    start0 = 1'b0;

    // Back-pressure: table held for 5 cycles.
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("hold_valid[%0d]", n), 32'(valid0), 32'd1);
      check($sformatf("hold_tt[%0d]", n),    32'(tt0),    32'h0000EEFC);
    end

    // Ready together with start: handshake completes, start ignored.
    ready0 = 1'b1; start0 = 1'b1;
    tick();
    ready0 = 1'b0; start0 = 1'b0;
    check("hs_valid", 32'(valid0), 32'd0);
    check("hs_busy",  32'(busy0),  32'd0);
    check("hs_x",     32'(x0),     32'd0);
    check("hs_tt",    32'(tt0),    32'h0000EEFC);
    tick();
    check("idle_busy",  32'(busy0),  32'd0);
    check("idle_valid", 32'(valid0), 32'd0);

    // Async reset during DRIVE of idx=5.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int j = 1; j <= 10; j++) tick();
    check("pre_rst_x", 32'(x0), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_x",     32'(x0),     32'd0);
    check("arst_busy",  32'(busy0),  32'd0);
    check("arst_valid", 32'(valid0), 32'd0);
    check("arst_tt",    32'(tt0),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Fresh sweep after reset.
`ifdef TT_CAPTURE_CHECK_EN
    exp0 = 16'hEEFC;
`endif
    start0 = 1'b1;
    sb_q.push_back(model_tt(1'b0));
    tick();
    start0 = 1'b0;
    cycles = 0;
    while (!valid0 && cycles < 40) begin
      tick();
      cycles++;
    end
    check("resweep_latency", 32'(cycles), 32'd16);
    check("resweep_valid",   32'(valid0), 32'd1);
    pop_check("resweep_tt_sb", tt0);
`ifdef TT_CAPTURE_CHECK_EN
    check("mismatch_eefc", 32'(mm0), 32'd0);
`endif
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;

    // SETTLE=0, constant circuit: one vector per cycle.
    start1 = 1'b1;
    sb_q.push_back(model_tt(1'b1));
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) tick();
      if (j < 8) begin
        check($sformatf("s0_x[%0d]", j),    32'(x1),    32'(j));
        check($sformatf("s0_busy[%0d]", j), 32'(busy1), 32'd1);
      end else begin
        check("s0_valid", 32'(valid1), 32'd1);
        check("s0_busy",  32'(busy1),  32'd0);
        check("s0_x",     32'(x1),     32'd0);
        pop_check("s0_tt_sb", tt1);
        check("s0_tt_const", 32'(tt1), 32'h000000FF);
      end
    end
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    check("s0_valid_drop", 32'(valid1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_capture.md
# tt_capture

Exhaustive stimulus driver and response collector for a generated combinational circuit (x inputs, f outputs). Walks every input vector, waits a programmable settle time, samples the circuit outputs and assembles the full per-output truth table. It hands the table downstream over a valid/ready handshake for dataset labelling and equivalence checking. The block sits directly around the circuit under test: `x` feeds its inputs and `f` consumes its outputs.

## Interface
- `N_IN`, 3, number of circuit inputs (1..8)
- `N_OUT`, 2, number of circuit outputs (1..8)
- `SETTLE`, 1, idle cycles between driving `x` and sampling `f` (0..15)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE
- `x`  out  N_IN  stimulus vector to the circuit; `x[0]` = x0
- `f`  in  N_OUT  circuit response; `f[0]` = f0
- `busy`  out  1  high from the accepted start until `tt_valid` rises
- `tt_valid`  out  1  truth table available
- `tt_ready`  in  1  downstream accepts the table
- `tt`  out  N_OUT*2^N_IN  packed table; bit `o*2^N_IN + i` = `f[o]` when `x == i`

## Operation
- States: IDLE, DRIVE, SAMPLE, OUT.
- IDLE: `x`=0, `busy`=0, `tt_valid`=0. `start`=1 → clear `tt`, idx=0, settle count=0 → DRIVE (or SAMPLE if SETTLE=0).
- DRIVE: `x`=idx. Count SETTLE cycles → SAMPLE.
- SAMPLE: `x`=idx still held. Write `f[o]` into `tt[o*2^N_IN+idx]` for all o.
  - If idx = 2^N_IN−1 → OUT.
  - Otherwise idx+1 → DRIVE (SAMPLE if SETTLE=0).
- OUT: `tt_valid`=1, `tt` stable, `x`=0. `tt_ready`=1 → IDLE. `tt` is held until the next accepted start.
- idx counter is N_IN+1 bits wide. It never wraps; the terminal value is checked before increment.
- `start` outside IDLE is ignored, including in OUT with `tt_ready`=1 in the same cycle. A new sweep needs `start` in a later IDLE cycle.
- Reset values: `x`=0, `busy`=0, `tt_valid`=0, `tt`=0, state IDLE, idx=0. Reset mid-sweep aborts immediately and discards the partial table.

## Timing
- Each input vector occupies exactly SETTLE+1 cycles with `x` stable. `f` is sampled at the final edge of that window.
- Start accepted at edge k → `tt_valid`=1 after edge k + 2^N_IN·(SETTLE+1). Example: N_IN=3, SETTLE=1 gives 16 cycles.
- `busy` falls in the same cycle `tt_valid` rises.
- `tt_valid` is held until the `tt_ready` handshake completes; minimum one cycle.
- `f` is treated as combinational from `x`. With SETTLE=0, the circuit path is single-cycle.

## Configuration
- `TT_CAPTURE_CHECK_EN` defined:
  - adds input `tt_exp` (N_OUT*2^N_IN) and output `mismatch` (N_OUT).
  - `mismatch[o]` = 1 if output o's slice of `tt` ≠ the same slice of `tt_exp`.
  - `mismatch` is registered on entry to OUT, valid while `tt_valid`=1, and 0 otherwise and at reset.
- Undefined: neither port exists and no compare logic is built.

## Structure
- `tt_capture_pkg`: state enum, `TT_W(N_IN,N_OUT)` width function, SETTLE counter width constant.
- One sub-module, `tt_capture_idx`: index/settle counter pair with a terminal flag. The FSM and table register stay in the top module.

## Test plan
- Circuit model f0 = x1|x2, f1 = x0|x1 (x0 = LSB); N_IN=3, N_OUT=2, SETTLE=1 → `tt` = 16'hEEFC and `tt_valid` 16 cycles after start.
- `tt_ready` held low for 5 cycles in OUT → `tt_valid` and `tt` stable for all 5. Ready pulse → IDLE, `tt_valid`=0 the next cycle.
- `start` pulsed at idx=3 mid-sweep and again in OUT together with `tt_ready` → no restart, table unchanged, back in IDLE.
- `rst` asserted asynchronously during DRIVE of idx=5 → immediately `x`=0, `busy`=0, `tt`=0. A subsequent start produces a complete, correct table.
- SETTLE=0, constant circuit f=2'b01 → `tt` = 16'h00FF after 8 cycles. Check `x` steps 0..7 one per cycle.
- With `TT_CAPTURE_CHECK_EN`: `tt_exp`=16'hEEFD against the model above → `mismatch`=2'b01. With `tt_exp`=16'hEEFC → 2'b00.
